// File: rtl/soc_trace_arbiter.sv
// Per-core trace event FIFOs serialized round-robin onto one output stream, with termination aggregation.
// Optional build macro TRACE_ARB_DROP_EN: drop events into full FIFOs (sticky overflow) instead of backpressuring.
module soc_trace_arbiter #(
    parameter int CORES      = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int ID_W      = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CORES-1:0]      ev_valid,
    input  logic [16*CORES-1:0]   ev_code,
    input  logic [32*CORES-1:0]   ev_data,
    output logic [CORES-1:0]      ev_ready,
    input  logic [CORES-1:0]      term_req,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ID_W-1:0]       out_core,
    output logic [15:0]           out_code,
    output logic [31:0]           out_data,
    output logic [CORES-1:0]      overflow,
    output logic                  all_done
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [47:0]      mem [CORES][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr [CORES];
    logic [PTR_W-1:0] rd_ptr [CORES];
    logic [CNT_W-1:0] count  [CORES];
    logic [CORES-1:0] full, empty, push, drop, pop_vec;
    logic [CORES-1:0] term_flag;
    logic [ID_W-1:0]  last, grant_idx;
    logic             grant_valid, load, is_done, drained;
    logic [1:0]       state;

    assign is_done = (state == S_DONE);
    assign load    = !out_valid || out_ready;
    assign all_done = is_done;

    always_comb begin
        for (int i = 0; i < CORES; i++) begin
            full[i]  = (count[i] == CNT_W'(FIFO_DEPTH));
            empty[i] = (count[i] == '0);
`ifdef TRACE_ARB_DROP_EN
            ev_ready[i] = !is_done;
            push[i]     = ev_valid[i] && !is_done && !full[i];
            drop[i]     = ev_valid[i] && !is_done && full[i];
`else
            ev_ready[i] = !full[i] && !is_done;
            push[i]     = ev_valid[i] && ev_ready[i];
            drop[i]     = 1'b0;
`endif
        end
    end

    // Search starts one past the last grant so every non-empty FIFO is served within CORES slots.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= CORES; k++) begin
            idx = (int'(last) + k) % CORES;
            if (!grant_valid && !empty[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
        for (int i = 0; i < CORES; i++) begin
            pop_vec[i] = load && grant_valid && (int'(grant_idx) == i);
        end
    end

    assign drained = (&empty) && !out_valid && !(|push);

    // NOTE: the storage array carries no reset; only pointers and counts define validity,
    // and every sequential block uses non-blocking assignments.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CORES; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= {ev_code[16*i +: 16], ev_data[32*i +: 32]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CORES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CORES; i++) begin
                if (push[i])    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop_vec[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (push[i] && !pop_vec[i])      count[i] <= count[i] + CNT_W'(1);
                else if (!push[i] && pop_vec[i]) count[i] <= count[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_core  <= '0;
            out_code  <= '0;
            out_data  <= '0;
            last      <= ID_W'(CORES - 1);
        end else if (load) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_core <= grant_idx;
                out_code <= mem[grant_idx][rd_ptr[grant_idx]][47:32];
                out_data <= mem[grant_idx][rd_ptr[grant_idx]][31:0];
                last     <= grant_idx;
            end
        end
    end

`ifdef TRACE_ARB_DROP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) overflow <= '0;
        else        overflow <= overflow | drop;
    end
`else
    assign overflow = '0;
`endif

    // An already-empty system may finish in the same edge that completes termination.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            term_flag <= '0;
            state     <= S_RUN;
        end else begin
            term_flag <= term_flag | term_req;
            case (state)
                S_RUN:   if (&(term_flag | term_req)) state <= drained ? S_DONE : S_DRAIN;
                S_DRAIN: if (drained) state <= S_DONE;
                default: state <= S_DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_trace_arbiter.sv
// Directed self-checking bench for soc_trace_arbiter (CORES=4, FIFO_DEPTH=4).
module tb_soc_trace_arbiter;
    localparam int CORES = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CORES-1:0]  ev_valid = '0;
    logic [16*CORES-1:0] ev_code = '0;
    logic [32*CORES-1:0] ev_data = '0;
    logic [CORES-1:0]  ev_ready;
    logic [CORES-1:0]  term_req = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        out_core;
    logic [15:0]       out_code;
    logic [31:0]       out_data;
    logic [CORES-1:0]  overflow;
    logic              all_done;

    int tests_run = 0;
    int tests_failed = 0;

    soc_trace_arbiter #(.CORES(CORES), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_code(ev_code), .ev_data(ev_data),
        .ev_ready(ev_ready), .term_req(term_req), .out_valid(out_valid), .out_ready(out_ready),
        .out_core(out_core), .out_code(out_code), .out_data(out_data), .overflow(overflow),
        .all_done(all_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0; ev_valid = '0; term_req = '0; out_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_ev(input int core, input logic [15:0] code, input logic [31:0] data);
        ev_code[16*core +: 16] = code;
        ev_data[32*core +: 32] = data;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run += 7;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        if (out_core !== 2'd0) begin tests_failed++; $display("FAIL reset_out_core: got %0d want 0", out_core); end
        if (out_code !== 16'h0) begin tests_failed++; $display("FAIL reset_out_code: got %0h want 0", out_code); end
        if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
        if (ev_ready !== 4'hF) begin tests_failed++; $display("FAIL reset_ev_ready: got %0h want f", ev_ready); end
        if (overflow !== 4'h0) begin tests_failed++; $display("FAIL reset_overflow: got %0h want 0", overflow); end
        if (all_done !== 1'b0) begin tests_failed++; $display("FAIL reset_all_done: got %0b want 0", all_done); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        ev_valid = 4'b0100;
        set_ev(2, 16'h0004, 32'h41);
        step();
        ev_valid = '0;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_latency: got valid %0b want 0", out_valid); end
        step();
        tests_run += 4;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %0b want 1", out_valid); end
        if (out_core !== 2'd2) begin tests_failed++; $display("FAIL single_core: got %0d want 2", out_core); end
        if (out_code !== 16'h0004) begin tests_failed++; $display("FAIL single_code: got %0h want 4", out_code); end
        if (out_data !== 32'h41) begin tests_failed++; $display("FAIL single_data: got %0h want 41", out_data); end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_after: got valid %0b want 0", out_valid); end
    endtask

    task automatic test_all_cores();
        do_reset();
        out_ready = 1'b1;
        ev_valid = 4'hF;
        for (int i = 0; i < CORES; i++) set_ev(i, 16'h0010 + 16'(i), 32'h100 + 32'(i));
        step();
        ev_valid = '0;
        for (int i = 0; i < CORES; i++) begin
            step();
            tests_run += 2;
            if (out_valid !== 1'b1 || out_core !== 2'(i)) begin
                tests_failed++; $display("FAIL rr_core_%0d: got valid %0b core %0d want core %0d", i, out_valid, out_core, i);
            end
            if (out_code !== 16'h0010 + 16'(i)) begin
                tests_failed++; $display("FAIL rr_code_%0d: got %0h want %0h", i, out_code, 16'h0010 + 16'(i));
            end
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_idle: got valid %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        int  sent;
        int  rx;
        bit  acc;
        bit  hold_bad;
        do_reset();
        sent = 0; hold_bad = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            ev_valid[1] = (sent < 6);
            set_ev(1, 16'h0200 + 16'(sent), 32'(sent));
            acc = ev_ready[1] && (sent < 6);
            step();
            if (acc) sent++;
            if (cyc >= 1 && (out_valid !== 1'b1 || out_data !== 32'h0)) hold_bad = 1;
        end
        ev_valid = '0;
        tests_run += 2;
        if (hold_bad) begin tests_failed++; $display("FAIL bp_hold: payload not held, got valid %0b data %0h want 1/0", out_valid, out_data); end
`ifdef TRACE_ARB_DROP_EN
        if (sent !== 6) begin tests_failed++; $display("FAIL bp_accept: got %0d pushes want 6", sent); end
        tests_run++;
        if (overflow[1] !== 1'b1) begin tests_failed++; $display("FAIL bp_overflow: got %0b want 1", overflow[1]); end
`else
        if (sent !== 5) begin tests_failed++; $display("FAIL bp_accept: got %0d pushes want 5", sent); end
        tests_run++;
        if (ev_ready[1] !== 1'b0) begin tests_failed++; $display("FAIL bp_ready: got %0b want 0", ev_ready[1]); end
`endif
        out_ready = 1'b1;
        rx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            acc = 0;
            if (sent < 6) begin
                ev_valid[1] = 1'b1;
                set_ev(1, 16'h0200 + 16'(sent), 32'(sent));
                acc = ev_ready[1];
            end else begin
                ev_valid = '0;
            end
            if (out_valid) begin
                tests_run++;
                if (out_data !== 32'(rx)) begin tests_failed++; $display("FAIL bp_order_%0d: got %0h want %0h", rx, out_data, rx); end
                rx++;
            end
            step();
            if (acc) sent++;
        end
        ev_valid = '0;
        tests_run++;
`ifdef TRACE_ARB_DROP_EN
        if (rx !== 5) begin tests_failed++; $display("FAIL bp_count: got %0d events want 5", rx); end
`else
        if (rx !== 6) begin tests_failed++; $display("FAIL bp_count: got %0d events want 6", rx); end
`endif
    endtask

    task automatic test_term();
        int hs;
        int last_hs;
        int first_done;
        do_reset();
        ev_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            set_ev(0, 16'h0300 + 16'(k), 32'h300 + 32'(k));
            step();
        end
        ev_valid = '0;
        term_req = 4'b0001; step();
        term_req = 4'b0000; step();
        term_req = 4'b0010; step();
        term_req = 4'b0000; step();
        term_req = 4'b1100; step();
        term_req = 4'b0000; step();
        tests_run++;
        if (all_done !== 1'b0) begin tests_failed++; $display("FAIL term_early: got all_done %0b want 0", all_done); end
        out_ready = 1'b1;
        hs = 0; last_hs = -10; first_done = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (all_done === 1'b1 && first_done < 0) first_done = cyc;
            if (out_valid) begin hs++; last_hs = cyc; end
            step();
        end
        tests_run += 4;
        if (hs !== 3) begin tests_failed++; $display("FAIL term_handshakes: got %0d want 3", hs); end
        if (first_done !== last_hs + 2) begin
            tests_failed++; $display("FAIL term_timing: all_done at slot %0d want %0d", first_done, last_hs + 2);
        end
        if (all_done !== 1'b1) begin tests_failed++; $display("FAIL term_hold: got %0b want 1", all_done); end
        if (ev_ready !== 4'h0) begin tests_failed++; $display("FAIL term_ready: got %0h want 0", ev_ready); end
        ev_valid = 4'hF;
        step(); step();
        ev_valid = '0;
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL term_refuse: got valid %0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        bit stale;
        do_reset();
        ev_valid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            set_ev(2, 16'h0400 + 16'(k), 32'h400 + 32'(k));
            step();
        end
        ev_valid = '0;
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre: got valid %0b want 1", out_valid); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        tests_run += 3;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_valid: got %0b want 0", out_valid); end
        if (ev_ready !== 4'hF) begin tests_failed++; $display("FAIL rstmid_ready: got %0h want f", ev_ready); end
        if (all_done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_done: got %0b want 0", all_done); end
        out_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (out_valid !== 1'b0) stale = 1;
        end
        tests_run++;
        if (stale) begin tests_failed++; $display("FAIL rstmid_stale: got stale event want none"); end
    endtask

    task automatic test_no_starve();
        bit seen0;
        bit seen1;
        do_reset();
        out_ready = 1'b1;
        ev_valid = 4'b1000;
        set_ev(3, 16'h0333, 32'h333);
        step(); step(); step();
        ev_valid = 4'b1011;
        set_ev(0, 16'h00A0, 32'hA0);
        set_ev(1, 16'h00A1, 32'hA1);
        step();
        ev_valid = 4'b1000;
        seen0 = 0; seen1 = 0;
        for (int s = 0; s < 3; s++) begin
            step();
            if (out_valid && out_core == 2'd0 && out_data == 32'hA0) seen0 = 1;
            if (out_valid && out_core == 2'd1 && out_data == 32'hA1) seen1 = 1;
        end
        ev_valid = '0;
        tests_run += 2;
        if (!seen0) begin tests_failed++; $display("FAIL starve_core0: got no core0 event in 3 slots want 1"); end
        if (!seen1) begin tests_failed++; $display("FAIL starve_core1: got no core1 event in 3 slots want 1"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_all_cores();
        test_backpressure();
        test_term();
        test_reset_mid();
        test_no_starve();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
